jump_pc: RTL and testbench
==========================

// Module: jump_pc
// PURPOSE
//  Hack-CPU program-counter stage directly downstream of the ALU flag logic.
//  Derives zr/ng from the ALU result and evaluates the instruction's jump bits.
//  Registers the next fetch address: load from A on a taken jump, else increment.
//  Inserts one flush bubble after every taken jump via a valid/ready handshake.
// PARAMETERS
//  WIDTH       16  address/data width in bits; must be a multiple of 8
//  RESET_ADDR  0   value loaded into pc_out on rst_n low or sreset
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  sreset    in   1      synchronous reset (Hack "reset" button)
//  in_valid  in   1      instruction beat (j, alu_out, a_in) is valid
//  in_ready  out  1      stage accepts a beat this cycle
//  j         in   3      jump bits {j1(lt), j2(eq), j3(gt)} = j[2], j[1], j[0]
//  alu_out   in   WIDTH  ALU result the flags derive from
//  a_in      in   WIDTH  A-register value (jump target)
//  pc_out    out  WIDTH  registered next fetch address
//  jumped    out  1      one-cycle pulse: previous accepted beat was a taken jump
//  flush     out  1      fetch stage must discard its current instruction
// BEHAVIOUR
//  - Reset (rst_n low, async): pc_out=RESET_ADDR, jumped=0, flush=0, state=RUN.
//    in_ready is 1 while rst_n is low and after release.
//  - Flags are combinational: ng = alu_out[WIDTH-1]; zr = ~|alu_out.
//  - taken = (j[2]&ng) | (j[1]&zr) | (j[0]&~ng&~zr).
//    j=000 never jumps; j=111 always jumps.
//  - States: RUN, FLUSH. in_ready = (state==RUN); flush = (state==FLUSH).
//  - RUN, no accept (in_valid=0): pc_out holds, jumped<=0, state stays RUN.
//  - RUN, accept, not taken: pc_out <= pc_out+1 mod 2^WIDTH; jumped<=0.
//  - RUN, accept, taken: pc_out <= a_in; jumped<=1; state -> FLUSH.
//    This holds even when a_in equals pc_out+1.
//  - FLUSH: lasts exactly one cycle. in_ready=0; in_valid is ignored;
//    pc_out holds; jumped<=0; next state RUN.
//  - Latency: pc_out updates on the first rising edge after acceptance.
//  - Wrap-around: pc_out 0xFFFF + 1 -> 0x0000 (WIDTH=16). No overflow flag.
//  - Priority per edge: rst_n > sreset > taken jump > increment > hold.
//    sreset wins over a simultaneous accepted jump:
//    pc_out=RESET_ADDR, jumped=0, state=RUN, no flush.
//  - rst_n asserted mid-FLUSH: FLUSH is abandoned and all outputs go to reset values.
//  - All outputs are registered except in_ready and flush, which decode state only.
// STRUCTURE
//  - Shared package hack_pkg holds:
//    - localparam HACK_W=16;
//    - the state enum {RUN, FLUSH};
//    - jump-bit index constants J_LT=2, J_EQ=1, J_GT=0.
//  - Sub-module jump_cond (combinational) takes j and alu_out and returns taken.
//    Internally, zr is built as a byte-wise OR-reduce from the existing Or8Way
//    gate: WIDTH/8 instances, NOR of their outputs.
//  - Top level holds the state register and the pc register.
// TESTING
//  1. Pulse rst_n low mid-count (pc_out=0x0005)
//     -> pc_out=0x0000, jumped=0, flush=0 immediately, before any clock edge.
//  2. From reset, 3 accepted beats with j=000
//     -> pc_out 0x0001, 0x0002, 0x0003; jumped stays 0; in_ready stays 1.
//  3. j=010, alu_out=0x0000, a_in=0x0040
//     -> pc_out=0x0040, jumped=1 for one cycle.
//     -> flush=1 and in_ready=0 for exactly one cycle, then back to RUN.
//  4. j=100, alu_out=0x8001 -> taken, pc_out=a_in.
//     j=001, alu_out=0x8001 -> not taken, pc_out+1.
//  5. pc_out=0xFFFF, accept j=000 -> pc_out=0x0000.
//  6. sreset=1 in the same cycle as an accepted taken jump to 0x0100
//     -> pc_out=RESET_ADDR, jumped=0, flush=0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack-CPU program-counter slice.
// Holds the default datapath width, the PC-stage state encoding and the
// bit positions of the three jump bits inside an instruction.
package hack_pkg;

  // Default address/data width of the Hack machine.
  localparam int HACK_W = 16;

  // Positions of the jump bits {j1, j2, j3} inside the 3-bit jump field.
  // J_LT jumps on a negative result.
  // J_EQ jumps on a zero result.
  // J_GT jumps on a strictly positive result.
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

  // PC stage states.
  // RUN accepts instruction beats.
  // FLUSH is the single bubble cycle that follows a taken jump.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_e;

  // Jump decision from the three jump bits and the two ALU flags.
  // Keeping this expression in one place keeps every user consistent.
  function automatic logic jump_taken(input logic [2:0] j,
                                      input logic       ng,
                                      input logic       zr);
    logic pos;
    pos        = ~ng & ~zr;
    jump_taken = (j[J_LT] & ng) | (j[J_EQ] & zr) | (j[J_GT] & pos);
  endfunction

endpackage

// File: rtl/Or8Way.sv
// Eight-input OR gate from the Hack gate library.
// Its output is high when any of the eight input bits is high.
module Or8Way (
  input  logic [7:0] in_i,
  output logic       out_o
);

  // Reduce the byte to a single "any bit set" indication.
  always_comb begin
    out_o = |in_i;
  end

endmodule

// File: rtl/jump_cond.sv
// Jump-condition evaluator.
// Derives the zr and ng flags from the ALU result and combines them with
// the jump bits. zr is built byte by byte from Or8Way gates, so the
// zero-detect tree matches the gate library used elsewhere in the CPU.
module jump_cond
  import hack_pkg::*;
#(
  parameter int WIDTH = HACK_W
) (
  input  logic [2:0]       j_i,
  input  logic [WIDTH-1:0] alu_out_i,
  output logic             taken_o
);

  localparam int NBYTES = WIDTH / 8;

  logic [NBYTES-1:0] byteAny;
  logic              zr;
  logic              ng;

  // A width that is not a whole number of bytes cannot be split across Or8Way gates.
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
    $error("jump_cond: WIDTH must be a non-zero multiple of 8");
  end

  // One Or8Way per byte; each reports whether its byte holds any set bit.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte_or
    Or8Way u_or8 (
      .in_i  (alu_out_i[b*8 +: 8]),
      .out_o (byteAny[b])
    );
  end

  // Zero when no byte has a set bit; negative when the sign bit is set.
  always_comb begin
    zr      = ~|byteAny;
    ng      = alu_out_i[WIDTH-1];
    taken_o = jump_taken(j_i, ng, zr);
  end

endmodule

// File: rtl/jump_pc.sv
// Hack-CPU program-counter stage.
// Registers the next fetch address. A taken jump loads the A value into the PC.
// Any other accepted beat increments the PC.
// Every taken jump is followed by one FLUSH cycle. During that cycle the stage
// refuses input, so the fetch stage can drop the instruction it fetched
// from the old, sequential address.
module jump_pc
  import hack_pkg::*;
#(
  parameter int              WIDTH      = HACK_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       j,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] a_in,
  output logic [WIDTH-1:0] pc_out,
  output logic             jumped,
  output logic             flush
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             jumped_q, jumped_d;
  logic             taken;
  logic             accept;

  jump_cond #(
    .WIDTH (WIDTH)
  ) u_jump_cond (
    .j_i       (j),
    .alu_out_i (alu_out),
    .taken_o   (taken)
  );

  // Handshake outputs decode the state directly, so a beat offered in RUN is accepted the same cycle.
  always_comb begin
    in_ready = (state_q == RUN);
    flush    = (state_q == FLUSH);
    accept   = in_valid & (state_q == RUN);
  end

  // Next-state selection; sreset overrides a jump, a jump overrides an increment, an increment overrides a hold.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    jumped_d = 1'b0;
    if (sreset) begin
      state_d = RUN;
      pc_d    = RESET_ADDR;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            if (taken) begin
              pc_d     = a_in;
              jumped_d = 1'b1;
              state_d  = FLUSH;
            end else begin
              pc_d = pc_q + WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State, PC and jump pulse registers; an asynchronous reset abandons any bubble in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_ADDR;
      jumped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      jumped_q <= jumped_d;
    end
  end

  // Registered outputs come straight from their flops.
  always_comb begin
    pc_out = pc_q;
    jumped = jumped_q;
  end

endmodule

// File: tb/tb_jump_pc.sv
// Self-checking bench for jump_pc at WIDTH=16, RESET_ADDR=0.
// Each vector in the table drives one beat and carries the outputs expected
// after the following rising edge. Those expectations go into a queue when
// the beat is driven. They are popped and compared one time unit after the edge.
// Hand-written sequences cover the asynchronous reset cases.
module tb_jump_pc;

  logic        clk;
  logic        rst_n;
  logic        sreset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  j;
  logic [15:0] alu_out;
  logic [15:0] a_in;
  logic [15:0] pc_out;
  logic        jumped;
  logic        flush;

  typedef struct {
    logic        sreset;
    logic        valid;
    logic [2:0]  j;
    logic [15:0] alu;
    logic [15:0] a;
    logic [15:0] expPc;
    logic        expJumped;
    logic        expFlush;
    logic        expReady;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic        jumped;
    logic        flush;
    logic        ready;
  } exp_t;

  exp_t sbQueue[$];
  vec_t tbl[23];
  int   checks   = 0;
  int   failures = 0;

  jump_pc #(
    .WIDTH      (16),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sreset   (sreset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .j        (j),
    .alu_out  (alu_out),
    .a_in     (a_in),
    .pc_out   (pc_out),
    .jumped   (jumped),
    .flush    (flush)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit, in case the run never reaches the summary line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic s, input logic v, input logic [2:0] jj,
                              input logic [15:0] alu, input logic [15:0] a,
                              input logic [15:0] pc, input logic jp,
                              input logic fl, input logic rdy);
    vec_t r;
    r.sreset    = s;
    r.valid     = v;
    r.j         = jj;
    r.alu       = alu;
    r.a         = a;
    r.expPc     = pc;
    r.expJumped = jp;
    r.expFlush  = fl;
    r.expReady  = rdy;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one beat at the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    sreset   = v.sreset;
    in_valid = v.valid;
    j        = v.j;
    alu_out  = v.alu;
    a_in     = v.a;
    e.pc     = v.expPc;
    e.jumped = v.expJumped;
    e.flush  = v.expFlush;
    e.ready  = v.expReady;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the registered outputs.
  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    if (sbQueue.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_sb_empty actual=0 required=1", tag);
    end else begin
      e = sbQueue.pop_front();
      checkVal({tag, "_pc"},     pc_out,          e.pc);
      checkVal({tag, "_jumped"}, {15'd0, jumped},   {15'd0, e.jumped});
      checkVal({tag, "_flush"},  {15'd0, flush},    {15'd0, e.flush});
      checkVal({tag, "_ready"},  {15'd0, in_ready}, {15'd0, e.ready});
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkVal({tag, "_pc"},     pc_out,            16'h0000);
    checkVal({tag, "_jumped"}, {15'd0, jumped},   16'h0000);
    checkVal({tag, "_flush"},  {15'd0, flush},    16'h0000);
    checkVal({tag, "_ready"},  {15'd0, in_ready}, 16'h0001);
  endtask

  task automatic asyncResetPulse(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues(tag);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sreset   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    sreset   = 1'b0;
    in_valid = 1'b0;
    j        = 3'b000;
    alu_out  = 16'h0000;
    a_in     = 16'h0000;

    //          sr  v  j       alu       a          pc       jp fl rdy
    tbl[0]  = mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 1);
    tbl[1]  = mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0002, 0, 0, 1);
    tbl[2]  = mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0003, 0, 0, 1);
    tbl[3]  = mk(0, 1, 3'b010, 16'h0000, 16'h0040, 16'h0040, 1, 1, 0);
    tbl[4]  = mk(0, 1, 3'b111, 16'h0000, 16'h0999, 16'h0040, 0, 0, 1);
    tbl[5]  = mk(0, 1, 3'b100, 16'h8001, 16'h0200, 16'h0200, 1, 1, 0);
    tbl[6]  = mk(0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0200, 0, 0, 1);
    tbl[7]  = mk(0, 1, 3'b001, 16'h8001, 16'h0777, 16'h0201, 0, 0, 1);
    tbl[8]  = mk(0, 1, 3'b001, 16'h0005, 16'h0300, 16'h0300, 1, 1, 0);
    tbl[9]  = mk(0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0300, 0, 0, 1);
    tbl[10] = mk(0, 0, 3'b111, 16'h0000, 16'h0abc, 16'h0300, 0, 0, 1);
    tbl[11] = mk(0, 1, 3'b000, 16'h0000, 16'h0abc, 16'h0301, 0, 0, 1);
    tbl[12] = mk(0, 1, 3'b111, 16'h1234, 16'h0302, 16'h0302, 1, 1, 0);
    tbl[13] = mk(0, 0, 3'b000, 16'h0000, 16'h0000, 16'h0302, 0, 0, 1);
    tbl[14] = mk(0, 1, 3'b110, 16'h0001, 16'h0500, 16'h0303, 0, 0, 1);
    tbl[15] = mk(0, 1, 3'b011, 16'h7fff, 16'hffff, 16'hffff, 1, 1, 0);
    tbl[16] = mk(0, 0, 3'b000, 16'h0000, 16'h0000, 16'hffff, 0, 0, 1);
    tbl[17] = mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    tbl[18] = mk(1, 1, 3'b111, 16'h0000, 16'h0100, 16'h0000, 0, 0, 1);
    tbl[19] = mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 1);
    tbl[20] = mk(0, 1, 3'b111, 16'h0000, 16'h0010, 16'h0010, 1, 1, 0);
    tbl[21] = mk(1, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1);
    tbl[22] = mk(0, 1, 3'b101, 16'h0000, 16'h0020, 16'h0001, 0, 0, 1);

    // Reset values while rst_n is held low across clock edges.
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Count up to 5, then pull rst_n low between edges.
    asyncResetPulse("pre_count");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'(i), 0, 0, 1));
      checkOutput($sformatf("count%0d", i));
    end
    asyncResetPulse("async_mid_count");

    // Enter FLUSH, then pull rst_n low while the bubble is in progress.
    applyStimulus(mk(0, 1, 3'b111, 16'h0000, 16'h0123, 16'h0123, 1, 1, 0));
    checkOutput("pre_flush_jump");
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_mid_flush");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    applyStimulus(mk(0, 1, 3'b000, 16'h0000, 16'h0000, 16'h0001, 0, 0, 1));
    checkOutput("post_flush_reset");

    checks++;
    if (sbQueue.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover actual=%0d required=0", sbQueue.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
